uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver for the memory-mapped UART at 0x1000000; the counterpart to the existing transmit path.
- Oversamples the asynchronous RX line with the system clock, deframes 8N1 frames (8E1 when the optional feature is compiled in), and presents each byte through a single-entry valid/ready holding register.
- Sits between the board RX pin and the UART register block, which reads bytes and clears error flags.

Parameters:
- CLKS_PER_BIT, 216, clocks per bit minus 1 (clk_freq/baudrate-1); counter width is $clog2(CLKS_PER_BIT+1).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- rx_data  output  8  received byte, stable while rx_valid
- rx_valid  output  1  holding register full
- rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready
- frame_error  output  1  sticky: stop bit sampled 0
- overrun  output  1  sticky: byte completed while holding register full
- err_clear  input  1  clears frame_error, overrun (and parity_error)

Behaviour:
- Reset: rx_data=0, rx_valid=0, frame_error=0, overrun=0; synchronizer flops=1; state=IDLE; counters=0.
- Synchronizer: rx passes through 2 flops to give rxs; all decisions use rxs.
- IDLE: on rxs==0, clear the bit counter and go to START.
- START: count to CLKS_PER_BIT/2 (integer division), then sample. If rxs==1 it is a false start: go to IDLE, no flag. Otherwise reset the counter and go to DATA.
- DATA: sample every CLKS_PER_BIT+1 clocks, i.e. at mid-bit. Bits are LSB first into a shift register. After bit index 7, go to STOP (PARITY first if enabled).
- STOP: sample after CLKS_PER_BIT+1 clocks.
  - rxs==1: byte complete, go to IDLE.
  - rxs==0: set frame_error, discard the byte, go to BREAK.
- BREAK: wait for rxs==1, then go to IDLE. A held-low line therefore yields exactly one frame_error.
- Delivery: on completion the byte loads into rx_data and rx_valid rises the clock after the stop-bit sample. Latency from the line falling edge to rx_valid is about 2 + 9.5 bit times (plus 1 bit time with parity).
- Handshake: rx_valid holds until a cycle with rx_valid&&rx_ready, after which it clears next cycle. rx_data must not change while rx_valid=1 and no handshake occurs.
- Overrun: a completion while rx_valid=1 and rx_ready=0 sets overrun. The new byte is dropped and the old byte kept.
- Simultaneous handshake and completion in the same cycle: the new byte loads, rx_valid stays 1, no overrun.
- err_clear: clears the sticky flags next cycle. If err_clear and a set event occur in the same cycle, set wins.
- Reception continues regardless of the error flags; the receiver returns to IDLE after every stop sample.
- Reset mid-frame: all state is abandoned immediately. If the line is low when reset releases, START is entered normally. A reset release mid-frame can therefore produce a frame_error.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: a PARITY state samples the 9th bit between DATA and STOP.
  - Output parity_error (1 bit, sticky, reset 0, cleared by err_clear) is set when the XOR of the 8 data bits and the parity bit is 1.
  - The byte is still delivered if the stop bit is good.
- Not defined: the port and state are absent; the frame is 8N1.

Test Plan:
- CLKS_PER_BIT=15, send 0xA5 (8N1), rx_ready=1 -> rx_valid pulses once, rx_data=0xA5, no flags.
- Send 0x3C, 0x81 back-to-back, rx_ready=0 until after the second frame -> rx_data=0x3C retained, overrun=1; err_clear -> overrun=0.
- Low glitch of 5 clocks on an idle line -> no rx_valid, no flags, state back to IDLE.
- Frame 0x55 with stop bit forced 0, then line held low for 40 bit times -> frame_error=1 exactly once, no rx_valid; after the line goes high, 0x12 is received correctly.
- Second frame completes in the same cycle rx_ready is asserted for the first -> first byte consumed, rx_data=new byte, rx_valid stays 1, overrun=0.
- UART_RX_PARITY_EN: send 0x07 with parity 1 -> no parity_error. Send 0x07 with parity 0 -> parity_error=1 and rx_data=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver with a single-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky parity_error output.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 216
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  input  logic       err_clear
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;
`endif

  state_t           state;
  logic [1:0]       sync;
  logic             rxs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             done;

  assign rxs = sync[1];

  // Deframer, holding register and sticky flags; a flag set later in the block overrides err_clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync        <= 2'b11;
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      done        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], rx};
      done <= 1'b0;

      if (err_clear) begin
        frame_error <= 1'b0;
        overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_error <= 1'b0;
`endif
      end

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            state <= S_STOP;
            if (^{rxs, shreg}) parity_error <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rxs) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= S_BRK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_BRK: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A completed byte replaces the held one only if the slot is empty or being drained.
      if (done && rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end else if (done) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames for uart_rx, checked against a frame-level model
// (queue of expected bytes plus flag predictions derived from each frame's bits).
module tb_uart_rx;
  localparam int unsigned CPB = 15;
  localparam int unsigned BT  = CPB + 1;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  // Negedges from the start-bit edge until the edge on which a completed byte is presented.
  localparam int unsigned DELIVER_NEG = (FRAME_BITS - 1) * BT + 11;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_error(frame_error),
    .overrun(overrun),
`ifdef UART_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] got[$];
  int         rd = 0;
  int         valid_rises = 0;
  int         ferr_rises = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] exp_q[$];

  // Consumer-side monitor: records every handshaken byte and counts flag rising edges.
  always @(posedge clock) begin
    if (rx_valid === 1'b1 && rx_ready === 1'b1) got.push_back(rx_data);
    if (rx_valid === 1'b1 && !prev_valid) valid_rises <= valid_rises + 1;
    if (frame_error === 1'b1 && !prev_ferr) ferr_rises <= ferr_rises + 1;
    prev_valid <= (rx_valid === 1'b1);
    prev_ferr  <= (frame_error === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic take(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    v = (got.size() > rd) ? got[rd] : 8'hxx;
    rd++;
    check(tag, 32'(v), 32'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives one whole frame starting at a negedge; par is used only with parity framing.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rx = 1'b0;
    idle(BT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(BT);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    idle(BT);
`endif
    rx = stop;
    idle(BT);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
  endtask

  initial begin
    int v0;
    int f0;
    logic [7:0] b;

    idle(3);
    reset = 1'b0;
    idle(1);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_error", 32'(frame_error), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
`ifdef UART_RX_PARITY_EN
    check("reset_parity_error", 32'(parity_error), 32'h0);
`endif
    idle(2 * BT);

    // Single frame with the consumer always ready.
    rx_ready = 1'b1;
    v0 = valid_rises;
    send_good(8'hA5);
    idle(2 * BT);
    check("a5_valid_pulses", 32'(valid_rises - v0), 32'd1);
    take("a5_data", 8'hA5);
    check("a5_frame_error", 32'(frame_error), 32'h0);
    check("a5_overrun", 32'(overrun), 32'h0);

    // Two back-to-back frames with nobody draining: second byte is an overrun.
    rx_ready = 1'b0;
    send_good(8'h3C);
    send_good(8'h81);
    idle(BT);
    check("ovr_rx_data_kept", 32'(rx_data), 32'h3C);
    check("ovr_rx_valid", 32'(rx_valid), 32'h1);
    check("ovr_overrun", 32'(overrun), 32'h1);
    check("ovr_frame_error", 32'(frame_error), 32'h0);
    pulse_clear();
    check("ovr_cleared", 32'(overrun), 32'h0);
    rx_ready = 1'b1;
    idle(2);
    rx_ready = 1'b0;
    take("ovr_drained", 8'h3C);
    check("ovr_valid_after_drain", 32'(rx_valid), 32'h0);

    // Short low glitch is a false start.
    v0 = valid_rises;
    rx_ready = 1'b1;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(3 * BT);
    check("glitch_no_valid", 32'(valid_rises - v0), 32'd0);
    check("glitch_frame_error", 32'(frame_error), 32'h0);
    check("glitch_overrun", 32'(overrun), 32'h0);
    send_good(8'h6B);
    idle(BT);
    take("glitch_recover", 8'h6B);

    // Bad stop bit followed by a long break: exactly one frame error, no byte.
    v0 = valid_rises;
    f0 = ferr_rises;
    send_frame(8'h55, ^8'h55, 1'b0);
    rx = 1'b0;
    idle(40 * BT);
    rx = 1'b1;
    idle(2 * BT);
    check("brk_frame_error", 32'(frame_error), 32'h1);
    check("brk_single_error", 32'(ferr_rises - f0), 32'd1);
    check("brk_no_valid", 32'(valid_rises - v0), 32'd0);
    pulse_clear();
    check("brk_cleared", 32'(frame_error), 32'h0);
    send_good(8'h12);
    idle(BT);
    take("brk_recover", 8'h12);

    // Completion on the very cycle the held byte is handshaken.
    rx_ready = 1'b0;
    send_good(8'hC3);
    fork
      send_good(8'h9E);
      begin
        idle(DELIVER_NEG);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    idle(2);
    take("same_cycle_first", 8'hC3);
    check("same_cycle_rx_data", 32'(rx_data), 32'h9E);
    check("same_cycle_rx_valid", 32'(rx_valid), 32'h1);
    check("same_cycle_overrun", 32'(overrun), 32'h0);
    rx_ready = 1'b1;
    idle(2);
    take("same_cycle_second", 8'h9E);

    // Random bytes with random idle gaps; every byte is delivered in order.
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_good(b);
      idle(int'($urandom_range(0, 20)));
    end
    idle(2 * BT);
    foreach (exp_q[i]) take("random_byte", exp_q[i]);
    check("random_no_flags", 32'({frame_error, overrun}), 32'h0);

`ifdef UART_RX_PARITY_EN
    // Even parity: data 0x07 has three ones, so parity bit 1 is correct.
    send_frame(8'h07, 1'b1, 1'b1);
    idle(BT);
    check("par_good_no_error", 32'(parity_error), 32'(^8'h07 ^ 1'b1));
    take("par_good_data", 8'h07);
    send_frame(8'h07, 1'b0, 1'b1);
    idle(BT);
    check("par_bad_error", 32'(parity_error), 32'(^8'h07 ^ 1'b0));
    take("par_bad_data", 8'h07);
    pulse_clear();
    check("par_cleared", 32'(parity_error), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
